// File: rtl/minmax_frame_packer_if.sv
// Stream bundle between the word source, the frame packer and the downstream
// min/max comparator. The master side feeds words and consumes frames; the
// slave side is the packer itself.
interface minmax_frame_packer_if #(
    parameter int WIDTH      = 8,
    parameter int NUM_INPUTS = 4
);
    localparam int CW = $clog2(NUM_INPUTS + 1);

    logic                        in_valid;
    logic                        in_ready;
    logic [WIDTH-1:0]            in_data;
    logic                        in_last;
    logic                        in_tc;
    logic                        in_max;
    logic                        out_valid;
    logic                        out_ready;
    logic [NUM_INPUTS*WIDTH-1:0] out_vec;
    logic                        out_tc;
    logic                        out_max;
    logic [CW-1:0]               out_count;

    modport master (
        output in_valid, in_data, in_last, in_tc, in_max, out_ready,
        input  in_ready, out_valid, out_vec, out_tc, out_max, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, in_tc, in_max, out_ready,
        output in_ready, out_valid, out_vec, out_tc, out_max, out_count
    );
endinterface

// File: rtl/minmax_frame_packer.sv
// Serial-to-parallel front end for the min/max comparator: packs NUM_INPUTS
// words (word 0 in the LSBs) plus the per-frame compare mode into one frame.
// Short frames are padded with a value that can never win the comparison.
// Storage is one assembly buffer plus one output register (two frames total).
module minmax_frame_packer #(
    parameter int WIDTH      = 8,
    parameter int NUM_INPUTS = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    minmax_frame_packer_if.slave bus
);
    localparam int CW = $clog2(NUM_INPUTS + 1);
    localparam int VW = NUM_INPUTS * WIDTH;

    localparam logic [0:0]    ST_COLLECT = 1'b0;
    localparam logic [0:0]    ST_FULL    = 1'b1;
    localparam logic [CW-1:0] LAST_SLOT  = CW'(NUM_INPUTS - 1);
    localparam logic [CW-1:0] ONE        = CW'(1);

    // Pad word that loses every comparison under the given mode.
    function automatic logic [WIDTH-1:0] pad_word(input logic tc, input logic is_max);
        logic [WIDTH-1:0] w;
        w = is_max ? '0 : '1;
        if (tc) w[WIDTH-1] = ~w[WIDTH-1];
        return w;
    endfunction

    logic [0:0]    state;
    logic [CW-1:0] count;      // words written; in FULL it holds the real word count
    logic [VW-1:0] asm_vec;
    logic          asm_tc;
    logic          asm_max;

    logic          out_valid_r;
    logic [VW-1:0] out_vec_r;
    logic          out_tc_r;
    logic          out_max_r;
    logic [CW-1:0] out_count_r;

    logic          in_fire;
    logic          out_fire;
    logic          complete;
    logic          load_new;   // completed frame goes straight to the output register
    logic          load_held;  // frame parked in the assembly buffer moves out
    logic          frame_tc;
    logic          frame_max;
    logic [VW-1:0] frame_vec;

    // in_ready depends only on registered state, never on out_ready.
    assign bus.in_ready  = (state == ST_COLLECT);
    assign bus.out_valid = out_valid_r;
    assign bus.out_vec   = out_vec_r;
    assign bus.out_tc    = out_tc_r;
    assign bus.out_max   = out_max_r;
    assign bus.out_count = out_count_r;

    assign in_fire   = bus.in_valid & (state == ST_COLLECT);
    assign out_fire  = out_valid_r & bus.out_ready;
    assign complete  = in_fire & (bus.in_last | (count == LAST_SLOT));
    assign load_new  = complete & (~out_valid_r | bus.out_ready);
    assign load_held = (state == ST_FULL) & bus.out_ready;
    assign frame_tc  = (count == '0) ? bus.in_tc  : asm_tc;
    assign frame_max = (count == '0) ? bus.in_max : asm_max;

    // Completed frame: stored words, the current word at slot count, pad above it.
    always_comb begin
        frame_vec = asm_vec;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (k == int'(count))
                frame_vec[k*WIDTH +: WIDTH] = bus.in_data;
            else if (k > int'(count))
                frame_vec[k*WIDTH +: WIDTH] = pad_word(frame_tc, frame_max);
        end
    end

    // Control: state, word count and the output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_COLLECT;
            count       <= '0;
            out_valid_r <= 1'b0;
            out_vec_r   <= '0;
            out_tc_r    <= 1'b0;
            out_max_r   <= 1'b0;
            out_count_r <= '0;
        end else begin
            if (load_new) begin
                out_vec_r   <= frame_vec;
                out_tc_r    <= frame_tc;
                out_max_r   <= frame_max;
                out_count_r <= count + ONE;
                out_valid_r <= 1'b1;
            end else if (load_held) begin
                out_vec_r   <= asm_vec;
                out_tc_r    <= asm_tc;
                out_max_r   <= asm_max;
                out_count_r <= count;
                out_valid_r <= 1'b1;
            end else if (out_fire) begin
                out_valid_r <= 1'b0;
            end

            if (load_held) begin
                state <= ST_COLLECT;
                count <= '0;
            end else if (in_fire) begin
                if (load_new) begin
                    count <= '0;
                end else begin
                    count <= count + ONE;
                    if (complete) state <= ST_FULL;
                end
            end
        end
    end

    // Assembly buffer: words and mode bits; a frame that must wait is parked padded.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            if (count == '0) begin
                asm_tc  <= bus.in_tc;
                asm_max <= bus.in_max;
            end
            if (complete && !load_new) begin
                asm_vec <= frame_vec;
            end else begin
                for (int k = 0; k < NUM_INPUTS; k++) begin
                    if (k == int'(count)) asm_vec[k*WIDTH +: WIDTH] <= bus.in_data;
                end
            end
        end
    end
endmodule
